// File: rtl/max7219_sequencer.sv
// -----------------------------------------------------------------------------
// max7219_sequencer
//
// Command sequencer that sits in front of an SPI master driving a MAX7219
// LED display driver. After reset it sends the MAX7219 init list. After that
// it refreshes the eight digit registers from an internal frame buffer, or
// reloads the intensity register, whenever either is requested. Only one SPI
// transaction is in flight at a time. The SPI master handshake is a
// spi_start pulse out and a spi_done pulse back.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   wr_en      in   frame buffer write strobe
//   wr_idx     in   digit index 0..7 (MAX7219 digit registers 0x01..0x08)
//   wr_data    in   digit segment data
//   update     in   pulse: request a full 8-digit refresh
//   int_wr     in   pulse: load int_val into the intensity register
//   int_val    in   new intensity value
//   spi_start  out  one-cycle pulse: begin an SPI transaction
//   spi_addr   out  MAX7219 register address, held until spi_done
//   spi_data   out  MAX7219 register data, held until spi_done
//   spi_done   in   one-cycle pulse from the SPI master: transaction finished
//   busy       out  high unless idle with nothing pending
//   init_done  out  high once the init list has completed; sticky until rst
//
// state      | meaning
// -----------+-------------------------------------------------------------
// INIT_ISSUE | spi_start high for the current init command
// INIT_WAIT  | waiting for spi_done of the current init command
// IDLE       | init complete; arbitrate pending intensity / refresh requests
// REF_ISSUE  | spi_start high for the current digit of a refresh
// REF_WAIT   | waiting for spi_done of the current digit
// INT_ISSUE  | spi_start high for the intensity command
// INT_WAIT   | waiting for spi_done of the intensity command
// -----------------------------------------------------------------------------
module max7219_sequencer #(
  parameter logic [7:0] DECODE_MODE    = 8'h00,
  parameter logic [2:0] SCAN_LIMIT     = 3'd7,
  parameter logic [3:0] INIT_INTENSITY = 4'h8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic       update,
  input  logic       int_wr,
  input  logic [3:0] int_val,
  output logic       spi_start,
  output logic [7:0] spi_addr,
  output logic [7:0] spi_data,
  input  logic       spi_done,
  output logic       busy,
  output logic       init_done
);

  localparam logic [2:0] INIT_LAST      = 3'd4;
  localparam logic [2:0] DIGIT_LAST     = 3'd7;
  localparam logic [7:0] ADDR_INTENSITY = 8'h0A;

  typedef enum logic [2:0] {
    INIT_ISSUE,
    INIT_WAIT,
    IDLE,
    REF_ISSUE,
    REF_WAIT,
    INT_ISSUE,
    INT_WAIT
  } state_t;

  state_t          state_q;
  logic [2:0]      init_step_q;
  logic [2:0]      digit_q;
  logic [7:0][7:0] fb_q;
  logic [7:0][7:0] snap_q;
  logic [3:0]      intensity_q;
  logic            ref_pend_q;
  logic            int_pend_q;
  logic            spi_start_q;
  logic [7:0]      spi_addr_q;
  logic [7:0]      spi_data_q;
  logic            busy_q;
  logic            init_done_q;

  // Init list as {addr, data}. Intensity is read live so that an int_wr
  // landing before step 3 is issued is already reflected in the init list.
  function automatic logic [15:0] init_cmd(input logic [2:0] step,
                                           input logic [3:0] inten);
    logic [15:0] cmd;
    case (step)
      3'd0:    cmd = {8'h0F, 8'h00};
      3'd1:    cmd = {8'h09, DECODE_MODE};
      3'd2:    cmd = {8'h0B, {5'b0, SCAN_LIMIT}};
      3'd3:    cmd = {8'h0A, {4'b0, inten}};
      default: cmd = {8'h0C, 8'h01};
    endcase
    return cmd;
  endfunction

  logic [2:0]  init_step_nx;
  logic [2:0]  digit_nx;
  logic [7:0]  digit_addr_nx;
  logic [15:0] init_cmd_cur;
  logic [15:0] init_cmd_nx;
  logic        req_any;

  assign init_step_nx  = init_step_q + 3'd1;
  assign digit_nx      = digit_q + 3'd1;
  assign digit_addr_nx = {5'b0, digit_nx} + 8'd1;
  assign init_cmd_cur  = init_cmd(init_step_q, intensity_q);
  assign init_cmd_nx   = init_cmd(init_step_nx, intensity_q);

  // busy is registered, so on any transition into IDLE it must already
  // account for requests arriving in the same cycle.
  assign req_any = ref_pend_q | int_pend_q | update | int_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT_ISSUE;
      init_step_q <= '0;
      digit_q     <= '0;
      fb_q        <= '0;
      snap_q      <= '0;
      intensity_q <= INIT_INTENSITY;
      ref_pend_q  <= 1'b0;
      int_pend_q  <= 1'b0;
      spi_start_q <= 1'b0;
      spi_addr_q  <= '0;
      spi_data_q  <= '0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      busy_q <= 1'b1;

      case (state_q)
        // Normally entered with spi_start_q already set and the command
        // preloaded. Straight out of reset the strobe is still low, so the
        // first command is loaded here instead.
        INIT_ISSUE: begin
          if (!spi_start_q) begin
            spi_start_q              <= 1'b1;
            {spi_addr_q, spi_data_q} <= init_cmd_cur;
          end else begin
            spi_start_q <= 1'b0;
            state_q     <= INIT_WAIT;
          end
        end

        INIT_WAIT: begin
          if (spi_done) begin
            if (init_step_q == INIT_LAST) begin
              init_step_q <= '0;
              init_done_q <= 1'b1;
              busy_q      <= req_any;
              state_q     <= IDLE;
            end else begin
              init_step_q              <= init_step_nx;
              {spi_addr_q, spi_data_q} <= init_cmd_nx;
              spi_start_q              <= 1'b1;
              state_q                  <= INIT_ISSUE;
            end
          end
        end

        IDLE: begin
          busy_q <= req_any;
          if (int_pend_q) begin
            int_pend_q  <= 1'b0;
            spi_addr_q  <= ADDR_INTENSITY;
            spi_data_q  <= {4'b0, intensity_q};
            spi_start_q <= 1'b1;
            state_q     <= INT_ISSUE;
          end else if (ref_pend_q) begin
            ref_pend_q  <= 1'b0;
            snap_q      <= fb_q;
            digit_q     <= '0;
            spi_addr_q  <= 8'h01;
            spi_data_q  <= fb_q[0];
            spi_start_q <= 1'b1;
            state_q     <= REF_ISSUE;
          end
        end

        REF_ISSUE: begin
          spi_start_q <= 1'b0;
          state_q     <= REF_WAIT;
        end

        REF_WAIT: begin
          if (spi_done) begin
            if (digit_q == DIGIT_LAST) begin
              digit_q <= '0;
              busy_q  <= req_any;
              state_q <= IDLE;
            end else begin
              digit_q     <= digit_nx;
              spi_addr_q  <= digit_addr_nx;
              spi_data_q  <= snap_q[digit_nx];
              spi_start_q <= 1'b1;
              state_q     <= REF_ISSUE;
            end
          end
        end

        INT_ISSUE: begin
          spi_start_q <= 1'b0;
          state_q     <= INT_WAIT;
        end

        INT_WAIT: begin
          if (spi_done) begin
            busy_q  <= req_any;
            state_q <= IDLE;
          end
        end

        default: begin
          spi_start_q <= 1'b0;
          state_q     <= INIT_ISSUE;
        end
      endcase

      if (wr_en) begin
        fb_q[wr_idx] <= wr_data;
      end
      if (int_wr) begin
        intensity_q <= int_val;
      end

      // Placed after the FSM so that a request arriving in the same cycle
      // its flag is consumed re-arms the flag rather than being lost.
      if (update) begin
        ref_pend_q <= 1'b1;
      end
      if (int_wr) begin
        int_pend_q <= 1'b1;
      end
    end
  end

  assign spi_start = spi_start_q;
  assign spi_addr  = spi_addr_q;
  assign spi_data  = spi_data_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;

endmodule
